// File: rtl/sid_regs.sv
// -----------------------------------------------------------------------------
// sid_regs -- bus-side register file of the SID.
//
// Turns 8-bit CPU writes into the per-voice frequency, pulse-width, control and
// envelope words, plus the filter settings. Reads return the paddles, the
// oscillator-3 and envelope-3 values, or the decaying data-bus latch for every
// write-only address.
//
// Ports:
//   clk, reset_n               clock (rising edge), async active-low reset
//   cs, we, addr, wdata        one-cycle access strobe, write enable, address, data
//   rdata, rvalid              registered read data and its one-cycle valid pulse
//   potx, poty, osc3, env3     read-only sources sampled on the access cycle
//   fcw1..3, pw1..3            voice frequency control words and pulse widths
//   control1..3, ad1..3, sr1..3  voice control, attack/decay, sustain/release
//   fc, res_filt, mode_vol     filter cutoff, resonance/routing, mode/volume
// -----------------------------------------------------------------------------
module sid_regs #(
  parameter int DECAY_CYCLES = 8000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rvalid,
  input  logic [7:0]  potx,
  input  logic [7:0]  poty,
  input  logic [7:0]  osc3,
  input  logic [7:0]  env3,
  output logic [15:0] fcw1,
  output logic [15:0] fcw2,
  output logic [15:0] fcw3,
  output logic [11:0] pw1,
  output logic [11:0] pw2,
  output logic [11:0] pw3,
  output logic [7:0]  control1,
  output logic [7:0]  control2,
  output logic [7:0]  control3,
  output logic [7:0]  ad1,
  output logic [7:0]  ad2,
  output logic [7:0]  ad3,
  output logic [7:0]  sr1,
  output logic [7:0]  sr2,
  output logic [7:0]  sr3,
  output logic [10:0] fc,
  output logic [7:0]  res_filt,
  output logic [7:0]  mode_vol
);

  localparam int              CW       = $clog2(DECAY_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(DECAY_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DECAY_CYCLES - 1);

  // Per-voice register banks, index 0 = voice 1.
  logic [15:0] fcw_q  [3];
  logic [11:0] pw_q   [3];
  logic [7:0]  ctrl_q [3];
  logic [7:0]  ad_q   [3];
  logic [7:0]  sr_q   [3];
  logic [10:0] fc_q;
  logic [7:0]  res_q;
  logic [7:0]  mode_q;

  logic [7:0]    latch_q;
  logic [CW-1:0] cnt_q;

  logic       wr_en;
  logic       rd_en;
  logic       rd_port;   // address 0x19..0x1C: a live read-only source
  logic [7:0] port_val;

  assign wr_en = cs & we;
  assign rd_en = cs & ~we;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    rd_port  = 1'b0;
    port_val = 8'h00;
    case (addr)
      5'h19:   begin rd_port = 1'b1; port_val = potx; end
      5'h1A:   begin rd_port = 1'b1; port_val = poty; end
      5'h1B:   begin rd_port = 1'b1; port_val = osc3; end
      5'h1C:   begin rd_port = 1'b1; port_val = env3; end
      default: ;
    endcase
  end

  // Write decode. Each byte lands independently; a 16-bit word is briefly
  // half-updated between its two byte writes.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the banks are a handful of flops, not a RAM, so they are all reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < 3; v++) begin
        fcw_q[v]  <= '0;
        pw_q[v]   <= '0;
        ctrl_q[v] <= '0;
        ad_q[v]   <= '0;
        sr_q[v]   <= '0;
      end
      fc_q   <= '0;
      res_q  <= '0;
      mode_q <= '0;
    end else if (wr_en) begin
      for (int v = 0; v < 3; v++) begin
        if (addr == 5'(7 * v))     fcw_q[v][7:0]  <= wdata;
        if (addr == 5'(7 * v + 1)) fcw_q[v][15:8] <= wdata;
        if (addr == 5'(7 * v + 2)) pw_q[v][7:0]   <= wdata;
        if (addr == 5'(7 * v + 3)) pw_q[v][11:8]  <= wdata[3:0];
        if (addr == 5'(7 * v + 4)) ctrl_q[v]      <= wdata;
        if (addr == 5'(7 * v + 5)) ad_q[v]        <= wdata;
        if (addr == 5'(7 * v + 6)) sr_q[v]        <= wdata;
      end
      case (addr)
        5'h15:   fc_q[2:0]  <= wdata[2:0];
        5'h16:   fc_q[10:3] <= wdata;
        5'h17:   res_q      <= wdata;
        5'h18:   mode_q     <= wdata;
        default: ;
      endcase
    end
  end

  // Bus latch with decay. Any write or a read-only-port read reloads it; a
  // load always beats expiry. Otherwise the counter saturates at DECAY_CYCLES
  // and the latch clears on the edge the counter gets there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_q <= '0;
      cnt_q   <= '0;
    end else if (wr_en || (rd_en && rd_port)) begin
      latch_q <= wr_en ? wdata : port_val;
      cnt_q   <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) latch_q <= 8'h00;
    end
  end

  // Read data is taken from the pre-edge latch, so a read on the expiry edge
  // still sees the old value. rdata holds until the next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) rdata <= rd_port ? port_val : latch_q;
    end
  end

  assign fcw1     = fcw_q[0];
  assign fcw2     = fcw_q[1];
  assign fcw3     = fcw_q[2];
  assign pw1      = pw_q[0];
  assign pw2      = pw_q[1];
  assign pw3      = pw_q[2];
  assign control1 = ctrl_q[0];
  assign control2 = ctrl_q[1];
  assign control3 = ctrl_q[2];
  assign ad1      = ad_q[0];
  assign ad2      = ad_q[1];
  assign ad3      = ad_q[2];
  assign sr1      = sr_q[0];
  assign sr2      = sr_q[1];
  assign sr3      = sr_q[2];
  assign fc       = fc_q;
  assign res_filt = res_q;
  assign mode_vol = mode_q;

endmodule

// File: tb/tb_sid_regs.sv
// -----------------------------------------------------------------------------
// tb_sid_regs -- self-checking bench for sid_regs.
//
// The stimulus process keeps a byte image of everything written and the time
// and value of the last bus-latch load; expected register outputs are derived
// from the byte image, expected read data from the load time. Read
// expectations go into a queue that a separate monitor drains on rvalid.
// -----------------------------------------------------------------------------
module tb_sid_regs;

  localparam int D = 40;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs, we;
  logic [4:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [7:0]  potx, poty, osc3, env3;
  logic [15:0] fcw1, fcw2, fcw3;
  logic [11:0] pw1, pw2, pw3;
  logic [7:0]  control1, control2, control3;
  logic [7:0]  ad1, ad2, ad3, sr1, sr2, sr3;
  logic [10:0] fc;
  logic [7:0]  res_filt, mode_vol;

  sid_regs #(.DECAY_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .potx(potx), .poty(poty), .osc3(osc3),
    .env3(env3), .fcw1(fcw1), .fcw2(fcw2), .fcw3(fcw3), .pw1(pw1), .pw2(pw2),
    .pw3(pw3), .control1(control1), .control2(control2), .control3(control3),
    .ad1(ad1), .ad2(ad2), .ad3(ad3), .sr1(sr1), .sr2(sr2), .sr3(sr3), .fc(fc),
    .res_filt(res_filt), .mode_vol(mode_vol)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         cyc    = 0;   // index of the most recent rising edge
  logic [7:0] mem [32];     // every byte written since reset
  logic [7:0] l_val;        // value of last latch load
  int         l_edge;       // edge index of last latch load

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per rvalid pulse and checks it arrived on
  // the edge right after its cs cycle.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (rvalid) begin
      if (q.size() == 0) begin
        check("rvalid_unexpected", 32'(rvalid), 32'd0);
      end else begin
        e = q.pop_front();
        check("rd_edge", cyc, e.edge_n);
        check("rdata", rdata, e.data);
      end
    end else if (q.size() > 0 && q[0].edge_n <= cyc) begin
      e = q.pop_front();
      check("rvalid_missing", 32'(rvalid), 32'd1);
    end
  end

  function automatic logic [15:0] m_fcw(int v);
    return {mem[7*v+1], mem[7*v]};
  endfunction
  function automatic logic [11:0] m_pw(int v);
    return {mem[7*v+3][3:0], mem[7*v+2]};
  endfunction

  task automatic check_regs();
    check("fcw1", fcw1, m_fcw(0));
    check("fcw2", fcw2, m_fcw(1));
    check("fcw3", fcw3, m_fcw(2));
    check("pw1", pw1, m_pw(0));
    check("pw2", pw2, m_pw(1));
    check("pw3", pw3, m_pw(2));
    check("control1", control1, mem[4]);
    check("control2", control2, mem[11]);
    check("control3", control3, mem[18]);
    check("ad1", ad1, mem[5]);
    check("ad2", ad2, mem[12]);
    check("ad3", ad3, mem[19]);
    check("sr1", sr1, mem[6]);
    check("sr2", sr2, mem[13]);
    check("sr3", sr3, mem[20]);
    check("fc", fc, {mem[22], mem[21][2:0]});
    check("res_filt", res_filt, mem[23]);
    check("mode_vol", mode_vol, mem[24]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    l_val  = 8'h00;
    l_edge = cyc;
  endtask

  // One access, sampled on the next rising edge; cs drops 2 time units later.
  task automatic issue(input logic w, input logic [4:0] a, input logic [7:0] d);
    int         e;
    logic [7:0] v;
    exp_t       x;
    @(negedge clk);
    cs = 1'b1; we = w; addr = a; wdata = d;
    e = cyc + 1;
    if (w) begin
      mem[a] = d;
      l_val  = d;
      l_edge = e;
    end else begin
      case (a)
        5'h19:   v = potx;
        5'h1A:   v = poty;
        5'h1B:   v = osc3;
        5'h1C:   v = env3;
        default: v = (e - l_edge <= D) ? l_val : 8'h00;
      endcase
      if (a >= 5'h19 && a <= 5'h1C) begin
        l_val  = v;
        l_edge = e;
      end
      x.edge_n = e;
      x.data   = v;
      q.push_back(x);
    end
    @(posedge clk);
    #2;
    cs = 1'b0; we = 1'b0;
    if (w) check_regs();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    potx = 8'h00; poty = 8'h00; osc3 = 8'h00; env3 = 8'h00;
    model_reset();
    #3;
    check("reset_rvalid", rvalid, 0);
    check("reset_rdata", rdata, 0);
    check_regs();
    #9 reset_n = 1'b1;

    // Voice 1 byte writes; pw1[11:8] takes only the low nibble.
    issue(1, 5'h00, 8'h34);
    issue(1, 5'h01, 8'h12);
    issue(1, 5'h03, 8'hFA);
    check("tp_fcw1", fcw1, 16'h1234);
    check("tp_pw1_hi", pw1[11:8], 4'hA);

    // Full voice-3 block.
    for (int i = 0; i < 7; i++) issue(1, 5'(5'h0E + i), 8'(i + 1));
    check("tp_fcw3", fcw3, 16'h0201);
    check("tp_pw3", pw3, 12'h403);
    check("tp_sr3", sr3, 8'h07);

    // Back-to-back reads of osc3 and env3.
    osc3 = 8'h5A; env3 = 8'hC3;
    issue(0, 5'h1B, 8'h00);
    issue(0, 5'h1C, 8'h00);

    // Decay: the read on the expiry edge sees the old value, the next one 0.
    issue(1, 5'h18, 8'h9F);
    issue(0, 5'h00, 8'h00);
    idle(D - 2);
    issue(0, 5'h00, 8'h00);
    issue(0, 5'h00, 8'h00);

    // Write landing exactly on the expiry edge wins, then ages normally.
    issue(1, 5'h07, 8'h11);
    idle(D - 1);
    issue(1, 5'h08, 8'h66);
    idle(D - 1);
    issue(0, 5'h1F, 8'h00);
    issue(0, 5'h1D, 8'h00);

    // Randomised traffic, with idle stretches straddling the expiry point.
    for (int n = 0; n < 400; n++) begin
      int         r;
      logic [4:0] a;
      potx = 8'($urandom); poty = 8'($urandom);
      osc3 = 8'($urandom); env3 = 8'($urandom);
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) == 0) ? 5'(5'h19 + $urandom_range(0, 3))
                                      : 5'($urandom_range(0, 31));
      if (r <= 3)      issue(1, a, 8'($urandom));
      else if (r <= 6) issue(0, a, 8'h00);
      else if (r <= 8) idle($urandom_range(1, 3));
      else             idle($urandom_range(D - 3, D + 2));
    end

    // Reset pulsed in the middle of a read: outputs clear at once, access lost.
    potx = 8'hA5;
    issue(0, 5'h19, 8'h00);
    issue(1, 5'h16, 8'hFF);
    issue(1, 5'h15, 8'hFF);
    check("tp_fc_full", fc, 11'h7FF);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = 5'h19;
    #2 reset_n = 1'b0;
    #1;
    check("async_fc", fc, 0);
    check("async_rdata", rdata, 0);
    check("async_rvalid", rvalid, 0);
    @(posedge clk);
    #2;
    cs = 1'b0;
    reset_n = 1'b1;
    model_reset();
    check("post_reset_rvalid", rvalid, 0);
    issue(1, 5'h15, 8'h05);
    check("post_reset_fc", fc, 11'h005);
    issue(0, 5'h02, 8'h00);

    idle(3);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
